multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle main controller for the RV32I core; it replaces the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the shared datapath's multiplexer selects, write enables and ALU operation class. Memory accesses use a request/ready handshake, so the core tolerates wait-state memories, and a retired-instruction counter and illegal-opcode trap are provided.

## Interface
- `OPCODE_W`, default 7: opcode field width.
- `CNT_W`, default 32: retired-instruction counter width.
- `WAIT_EN`, default 1: when 1, memory states wait on `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in `OPCODE_W`: opcode field of the instruction register, valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `adr_src` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register (and oldPC).
- `pc_write` out 1: unconditional PC update.
- `branch` out 1: conditional PC update; the datapath gates it with ALU zero.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: ALU A select, 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B select, 00 = rs2, 01 = imm, 10 = constant 4.
- `result_src` out 2: result select, 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_op` out 2: ALU operation class, 00 = add, 01 = sub, 10 = R-type funct decode, 11 = I-type funct decode.
- `imm_src` out 3: immediate format, 000 = I, 001 = S, 010 = B, 011 = J.
- `illegal_instr` out 1: one-cycle pulse in TRAP.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
- Opcodes handled:
  - R 0110011
  - I-ALU 0010011
  - LW 0000011
  - SW 0100011
  - BEQ 1100011
  - JAL 1101111
  - Any other opcode is illegal.
- Every output not listed for a state is 0, including select fields. Outputs are Moore functions of state, except that `ir_write` and `pc_write` in FETCH are additionally gated by effective ready.
- Effective ready is `rdy = mem_ready | ~WAIT_EN`.
- States and outputs:
  - FETCH: `mem_read`=1, `adr_src`=0, a=00, b=10, op=00, `result_src`=10; `ir_write` = `pc_write` = `rdy`. Go to DECODE if `rdy`, else stay.
  - DECODE: a=01, b=01, op=00 (computes the branch/jump target). Next state by opcode: LW/SW → MEMADR, R → EXECR, I-ALU → EXECI, BEQ → BEQ, JAL → JAL, otherwise TRAP.
  - MEMADR: a=10, b=01, op=00. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: `mem_read`=1, `adr_src`=1. Go to MEMWB if `rdy`, else stay.
  - MEMWB: `result_src`=01, `reg_write`=1. Go to FETCH.
  - MEMWR: `mem_write`=1, `adr_src`=1. Go to FETCH if `rdy`, else stay.
  - EXECR: a=10, b=00, op=10. Go to ALUWB.
  - EXECI: a=10, b=01, op=11. Go to ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Go to FETCH.
  - BEQ: a=10, b=00, op=01, `result_src`=00, `branch`=1. Go to FETCH.
  - JAL: a=01, b=10, op=00, `result_src`=00, `pc_write`=1. Go to ALUWB, which writes PC+4 to rd.
  - TRAP: `illegal_instr`=1. Go to FETCH. The instruction does not retire and has no architectural side effects.
- `imm_src` is a combinational decode of `opcode`:
  - LW, I-ALU → 000
  - SW → 001
  - BEQ → 010
  - JAL → 011
  - anything else → 000
- `retired` increments by 1 on the cycle the FSM leaves MEMWB, MEMWR (with `rdy`), ALUWB or BEQ. It wraps modulo 2^`CNT_W` with no saturation.

## Timing
- Reset (asynchronous assert, synchronous release): state = FETCH, `retired` = 0. All outputs take their FETCH values immediately, with `ir_write` and `pc_write` low unless `rdy`.
- Reset asserted mid-instruction aborts it at once; there is no partial write after reset.
- Cycles per instruction at zero wait, counted from FETCH entry to the next FETCH entry:
  - R, I-ALU, SW, JAL: 4
  - LW: 5
  - BEQ: 3
  - illegal: 3
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- `mem_read`/`mem_write` and `adr_src` stay stable while waiting.
- `mem_ready` is only sampled in memory states; if high elsewhere it is ignored.
- `mem_ready` held high continuously gives zero-wait behaviour.
- `opcode` is sampled only in DECODE and MEMADR, and must be stable from DECODE until FETCH is re-entered.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode localparams
  - the state enum (4-bit encoding)
  - the `alu_src_a`, `alu_src_b`, `result_src`, `alu_op` and `imm_src` encodings
- Natural sub-module: `instr_decoder`, the purely combinational opcode → `imm_src` and class decode (R/I/LW/SW/BEQ/JAL/illegal). The FSM and counter stay in the top.

## Test plan
- R then I-ALU, `mem_ready`=1 throughout: each takes 4 cycles, `reg_write` pulses once in ALUWB, `alu_op` is 10 then 11, and `retired` = 2.
- LW with 3 wait cycles in FETCH and 2 in MEMRD: 10 cycles total, `mem_read` held, `adr_src`=1 during the MEMRD wait, `retired` += 1.
- SW followed by BEQ: 4 + 3 cycles, `mem_write` high only in MEMWR, `branch` high only in the BEQ state, `imm_src` is 001 then 010.
- JAL: DECODE → JAL → ALUWB, with `pc_write` in JAL and `reg_write` in ALUWB, `imm_src`=011, 4 cycles.
- Opcode 1111111: DECODE → TRAP, `illegal_instr` pulses 1 cycle, no `reg_write`/`mem_write`, `retired` unchanged, FETCH follows.
- `rst_n` low during MEMRD wait: state returns to FETCH asynchronously and `retired` = 0. With `CNT_W`=4 and 16 instructions retired, `retired` wraps to 0. With `WAIT_EN`=0 and `mem_ready`=0, LW still takes 5 cycles.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Opcodes, FSM states, datapath select codes, control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_JAL,
    CL_ILL
  } instr_class_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       jump;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [1:0] op;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.fetch    = 1'b1;
        c.src_a    = SRCA_PC;
        c.src_b    = SRCB_FOUR;
        c.op       = ALUOP_ADD;
        c.res      = RES_ALU;
      end
      S_DECODE: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        c.res       = RES_RDATA;
        c.reg_write = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_RS2;
        c.op    = ALUOP_RTYPE;
      end
      S_EXECI: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
        c.op    = ALUOP_ITYPE;
      end
      S_ALUWB: begin
        c.res       = RES_ALUOUT;
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_RS2;
        c.op     = ALUOP_SUB;
        c.branch = 1'b1;
      end
      S_JAL: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_FOUR;
        c.jump  = 1'b1;
      end
      S_TRAP: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request/ready handshake between controller and memory.
// The controller is master; memory answers with mem_ready.
interface multicycle_controller_if;
  logic mem_read;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Opcode to instruction class and immediate format.
// Purely combinational; unknown opcodes map to CL_ILL.
module instr_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls,
  output logic [2:0]          imm_src
);

  // One-hot opcode match into class and immediate format
  always_comb begin
    cls     = CL_ILL;
    imm_src = IMM_I;
    unique case (1'b1)
      (opcode == OPCODE_W'(OP_R)):   cls = CL_R;
      (opcode == OPCODE_W'(OP_I)):   cls = CL_I;
      (opcode == OPCODE_W'(OP_LW)):  cls = CL_LW;
      (opcode == OPCODE_W'(OP_SW)): begin
        cls     = CL_SW;
        imm_src = IMM_S;
      end
      (opcode == OPCODE_W'(OP_BEQ)): begin
        cls     = CL_BEQ;
        imm_src = IMM_B;
      end
      (opcode == OPCODE_W'(OP_JAL)): begin
        cls     = CL_JAL;
        imm_src = IMM_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main controller FSM for the RV32I core.
// Registered Moore outputs, wait-state memory, retire counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int CNT_W    = 32,
  parameter int WAIT_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_W-1:0]     opcode,
  multicycle_controller_if.master mem,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    branch,
  output logic                    reg_write,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_op,
  output logic [2:0]              imm_src,
  output logic                    illegal_instr,
  output logic [CNT_W-1:0]        retired
);

  localparam bit WAIT = (WAIT_EN != 0);

  state_t       state;
  state_t       nxt;
  ctrl_t        ctrl_q;
  instr_class_t cls;
  logic         rdy;
  logic         retire;

  instr_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .imm_src (imm_src)
  );

  assign rdy = mem.mem_ready | ~WAIT;

  // Next-state selection from current state, class and ready
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (cls == CL_LW),
          (cls == CL_SW):  nxt = S_MEMADR;
          (cls == CL_R):   nxt = S_EXECR;
          (cls == CL_I):   nxt = S_EXECI;
          (cls == CL_BEQ): nxt = S_BEQ;
          (cls == CL_JAL): nxt = S_JAL;
          default:         nxt = S_TRAP;
        endcase
      end
      S_MEMADR: nxt = (cls == CL_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_EXECR:  nxt = S_ALUWB;
      S_EXECI:  nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BEQ:    nxt = S_FETCH;
      S_JAL:    nxt = S_ALUWB;
      S_TRAP:   nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // State register with outputs pre-decoded for the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_of(S_FETCH);
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_of(nxt);
    end
  end

  assign retire = (state == S_MEMWB)
                | (state == S_ALUWB)
                | (state == S_BEQ)
                | ((state == S_MEMWR) & rdy);

  // Retired-instruction counter, wraps freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 1'b1;
    end
  end

  assign mem.mem_read  = ctrl_q.mem_read;
  assign mem.mem_write = ctrl_q.mem_write;
  assign mem.adr_src   = ctrl_q.adr_src;
  assign ir_write      = ctrl_q.fetch & rdy;
  assign pc_write      = (ctrl_q.fetch & rdy) | ctrl_q.jump;
  assign branch        = ctrl_q.branch;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.src_a;
  assign alu_src_b     = ctrl_q.src_b;
  assign result_src    = ctrl_q.res;
  assign alu_op        = ctrl_q.op;
  assign illegal_instr = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller, two configurations.
// Lane 0: CNT_W=4, WAIT_EN=1. Lane 1: CNT_W=32, WAIT_EN=0.
module tb_multicycle_controller;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        adr;
    logic        irw;
    logic        pcw;
    logic        br;
    logic        rw;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  rs;
    logic [1:0]  op;
    logic [2:0]  imm;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic        clk;
  logic        rst_n [2];
  logic        mr    [2];
  logic [6:0]  opc   [2];
  logic [31:0] cnt   [2];
  exp_t        q     [2][$];
  string       nq    [2][$];
  int          checks;
  int          failures;

  logic        irw0, pcw0, br0, rw0, ill0;
  logic [1:0]  a0, b0, rs0, op0;
  logic [2:0]  imm0;
  logic [3:0]  ret0;
  logic        irw1, pcw1, br1, rw1, ill1;
  logic [1:0]  a1, b1, rs1, op1;
  logic [2:0]  imm1;
  logic [31:0] ret1;
  exp_t        got0, got1;

  multicycle_controller_if bus0 ();
  multicycle_controller_if bus1 ();

  assign bus0.mem_ready = mr[0];
  assign bus1.mem_ready = mr[1];

  multicycle_controller #(
    .OPCODE_W (7), .CNT_W (4), .WAIT_EN (1)
  ) dut0 (
    .clk (clk), .rst_n (rst_n[0]), .opcode (opc[0]), .mem (bus0),
    .ir_write (irw0), .pc_write (pcw0), .branch (br0),
    .reg_write (rw0), .alu_src_a (a0), .alu_src_b (b0),
    .result_src (rs0), .alu_op (op0), .imm_src (imm0),
    .illegal_instr (ill0), .retired (ret0)
  );

  multicycle_controller #(
    .OPCODE_W (7), .CNT_W (32), .WAIT_EN (0)
  ) dut1 (
    .clk (clk), .rst_n (rst_n[1]), .opcode (opc[1]), .mem (bus1),
    .ir_write (irw1), .pc_write (pcw1), .branch (br1),
    .reg_write (rw1), .alu_src_a (a1), .alu_src_b (b1),
    .result_src (rs1), .alu_op (op1), .imm_src (imm1),
    .illegal_instr (ill1), .retired (ret1)
  );

  assign got0 = {bus0.mem_read, bus0.mem_write, bus0.adr_src,
                 irw0, pcw0, br0, rw0, a0, b0, rs0, op0, imm0,
                 ill0, 28'd0, ret0};
  assign got1 = {bus1.mem_read, bus1.mem_write, bus1.adr_src,
                 irw1, pcw1, br1, rw1, a1, b1, rs1, op1, imm1,
                 ill1, ret1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BQ) return 3'b010;
    if (o == JL) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [31:0] mask(input int l);
    return (l == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  // Output vector a phase must show, straight from the state table
  function automatic exp_t mk(input string ph, input logic re,
                              input logic [2:0] imm,
                              input logic [31:0] ret);
    exp_t e;
    e = '0;
    e.imm = imm;
    e.ret = ret;
    case (ph)
      "F": begin
        e.mr = 1; e.b = 2'b10; e.rs = 2'b10;
        e.irw = re; e.pcw = re;
      end
      "D":   begin e.a = 2'b01; e.b = 2'b01; end
      "MA":  begin e.a = 2'b10; e.b = 2'b01; end
      "MR":  begin e.mr = 1; e.adr = 1; end
      "MWB": begin e.rs = 2'b01; e.rw = 1; end
      "MW":  begin e.mw = 1; e.adr = 1; end
      "XR":  begin e.a = 2'b10; e.op = 2'b10; end
      "XI":  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b11; end
      "AWB": e.rw = 1;
      "BQ":  begin e.a = 2'b10; e.op = 2'b01; e.br = 1; end
      "J":   begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
      "T":   e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input int l, input string nm, input exp_t e);
    exp_t g;
    g = (l == 0) ? got0 : got1;
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s lane%0d t=%0t got=%h want=%h",
               nm, l, $time, g, e);
    end
  endtask

  // Monitor: compare each presented cycle against the scoreboard
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (q[l].size() > 0) begin
        chk(l, nq[l].pop_front(), q[l].pop_front());
      end
    end
  end

  task automatic step(input int l, input logic r, input string ph,
                      input logic re, input logic [6:0] o);
    @(posedge clk);
    #1;
    rst_n[l] = 1'b1;
    opc[l]   = o;
    mr[l]    = r;
    q[l].push_back(mk(ph, re, imm_of(o), cnt[l] & mask(l)));
    nq[l].push_back(ph);
  endtask

  task automatic mem_ph(input int l, input string ph, input int w,
                        input logic [6:0] o, input bit f0);
    if (l == 0) begin
      repeat (w) step(l, 1'b0, ph, 1'b0, o);
      step(l, 1'b1, ph, 1'b1, o);
    end else begin
      step(l, f0 ? 1'b0 : 1'($urandom), ph, 1'b1, o);
    end
  endtask

  task automatic oth(input int l, input string ph,
                     input logic [6:0] o, input bit f0);
    step(l, f0 ? 1'b0 : 1'($urandom), ph, 1'b0, o);
  endtask

  task automatic instr(input int l, input logic [6:0] o,
                       input int fw, input int mw, input bit f0);
    bit legal;
    legal = 1;
    mem_ph(l, "F", fw, o, f0);
    oth(l, "D", o, f0);
    if (o == LW) begin
      oth(l, "MA", o, f0);
      mem_ph(l, "MR", mw, o, f0);
      oth(l, "MWB", o, f0);
    end else if (o == SW) begin
      oth(l, "MA", o, f0);
      mem_ph(l, "MW", mw, o, f0);
    end else if (o == R) begin
      oth(l, "XR", o, f0);
      oth(l, "AWB", o, f0);
    end else if (o == I) begin
      oth(l, "XI", o, f0);
      oth(l, "AWB", o, f0);
    end else if (o == BQ) begin
      oth(l, "BQ", o, f0);
    end else if (o == JL) begin
      oth(l, "J", o, f0);
      oth(l, "AWB", o, f0);
    end else begin
      oth(l, "T", o, f0);
      legal = 0;
    end
    if (legal) cnt[l] = cnt[l] + 1;
  endtask

  task automatic rnd_instr(input int l);
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = R;
      1: o = I;
      2: o = LW;
      3: o = SW;
      4: o = BQ;
      5: o = JL;
      default: o = 7'($urandom);
    endcase
    instr(l, o, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
  endtask

  task automatic lane(input int l);
    rst_n[l] = 1'b0;
    mr[l]    = 1'b0;
    opc[l]   = 7'd0;
    cnt[l]   = '0;
    repeat (2) @(negedge clk);
    chk(l, "reset_state", mk("F", (l == 1), 3'b000, 32'd0));
    if (l == 0) begin
      instr(0, R, 0, 0, 0);
      instr(0, I, 0, 0, 0);
      instr(0, LW, 3, 2, 0);
      instr(0, SW, 0, 0, 0);
      instr(0, BQ, 0, 0, 0);
      instr(0, JL, 0, 0, 0);
      instr(0, 7'h7f, 0, 0, 0);
      for (int k = 0; k < 30; k++) rnd_instr(0);
      step(0, 1'b1, "F", 1'b1, LW);
      oth(0, "D", LW, 0);
      oth(0, "MA", LW, 0);
      step(0, 1'b0, "MR", 1'b0, LW);
      step(0, 1'b0, "MR", 1'b0, LW);
      @(negedge clk);
      #1;
      rst_n[0] = 1'b0;
      cnt[0]   = '0;
      #1;
      chk(0, "reset_async", mk("F", 1'b0, 3'b000, 32'd0));
      for (int k = 0; k < 20; k++) rnd_instr(0);
    end else begin
      instr(1, LW, 0, 0, 1);
      instr(1, SW, 0, 0, 1);
      instr(1, 7'h7f, 0, 0, 0);
      for (int k = 0; k < 40; k++) rnd_instr(1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fork
      lane(0);
      lane(1);
    join
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog t=%0t got=timeout want=done", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
